// File: rtl/periph_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// periph_reg_arbiter_pkg
//   Shared types and constants for the peripheral register-bus arbiter.
//   Contents:
//     state_e    - arbiter FSM states (IDLE, BUSY, ABORT)
//     ERR_RDATA  - read data returned to a master whose transaction timed out
// ---------------------------------------------------------------------------
package periph_reg_arbiter_pkg;

    // IDLE waits for a request, BUSY drives the slave, ABORT answers a
    // transaction the slave never completed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    // Recognisable pattern so software can tell a timeout apart from real data.
    localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

endpackage

// File: rtl/periph_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// periph_reg_arbiter_if
//   Bundles the requester side (packed per-requester request fields plus the
//   shared response) and the single peripheral-bus side of the arbiter.
//   Modports:
//     slave  - the arbiter's view: takes requests, answers them, drives slv_*
//     master - the surroundings' view: requesters plus the peripheral bus
//   Signals:
//     req_valid_i/req_write_i [NUM_REQ]   per-requester valid and direction
//     req_addr_i  [NUM_REQ*AW]            requester i at [i*AW +: AW]
//     req_wdata_i [NUM_REQ*DW]            requester i at [i*DW +: DW]
//     req_wstrb_i [NUM_REQ*DW/8]          requester i at [i*DW/8 +: DW/8]
//     rsp_ready_o [NUM_REQ]               one-hot completion strobe
//     rsp_rdata_o [DW], rsp_error_o       shared response payload
//     slv_valid_o/write/addr/wdata/wstrb  latched request to the peripheral bus
//     slv_ready_i/rdata_i/error_i         peripheral bus completion
// ---------------------------------------------------------------------------
interface periph_reg_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_write_i;
    logic [NUM_REQ*AW-1:0]     req_addr_i;
    logic [NUM_REQ*DW-1:0]     req_wdata_i;
    logic [NUM_REQ*DW/8-1:0]   req_wstrb_i;

    logic [NUM_REQ-1:0]        rsp_ready_o;
    logic [DW-1:0]             rsp_rdata_o;
    logic                      rsp_error_o;

    logic                      slv_valid_o;
    logic                      slv_write_o;
    logic [AW-1:0]             slv_addr_o;
    logic [DW-1:0]             slv_wdata_o;
    logic [DW/8-1:0]           slv_wstrb_o;
    logic                      slv_ready_i;
    logic [DW-1:0]             slv_rdata_i;
    logic                      slv_error_i;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        output rsp_ready_o, rsp_rdata_o, rsp_error_o,
        output slv_valid_o, slv_write_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
        input  slv_ready_i, slv_rdata_i, slv_error_i
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
        input  rsp_ready_o, rsp_rdata_o, rsp_error_o,
        input  slv_valid_o, slv_write_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
        output slv_ready_i, slv_rdata_i, slv_error_i
    );

endinterface

// File: rtl/periph_reg_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// periph_reg_arbiter_rr_pick
//   Combinational round-robin picker: returns the first set bit of i_valid
//   found when scanning upward from i_rrPtr, wrapping at NUM_REQ.
//   Ports:
//     i_valid  [NUM_REQ]  request vector
//     i_rrPtr  [GW]       requester with highest priority this round
//     o_found             at least one request is set
//     o_idx    [GW]       index of the chosen requester (0 when none)
// ---------------------------------------------------------------------------
module periph_reg_arbiter_rr_pick #(
    parameter int  NUM_REQ = 2,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [GW-1:0]      i_rrPtr,
    output logic               o_found,
    output logic [GW-1:0]      o_idx
);

    // Walk the offsets from the pointer; the first hit wins and later hits
    // are ignored. NUM_REQ need not be a power of two, so the wrap is an
    // explicit subtract rather than relying on index overflow.
    always_comb begin
        int            cand;
        logic [GW-1:0] candIdx;
        o_found = 1'b0;
        o_idx   = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(i_rrPtr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = GW'(cand);
            if (!o_found && i_valid[candIdx]) begin
                o_found = 1'b1;
                o_idx   = candIdx;
            end
        end
    end

endmodule

// File: rtl/periph_reg_arbiter.sv
// ---------------------------------------------------------------------------
// periph_reg_arbiter
//   Shares one peripheral register-bus port between NUM_REQ valid/ready
//   requesters using round-robin arbitration. One transaction is in flight at
//   a time; the granted request is latched so requester-side changes cannot
//   disturb the slave. A slave that never answers is cut off after
//   TIMEOUT_CYCLES with an error response (0 disables the timeout).
//   Ports:
//     clk_i, rst_i  clock and asynchronous active-high reset
//     bus_if        requester and peripheral-bus signals (slave modport)
//     busy_o        arbiter is not idle
//     grant_idx_o   index of the current or most recent grant
//     timeout_o     one-cycle pulse while a timed-out transaction is answered
// ---------------------------------------------------------------------------
module periph_reg_arbiter
    import periph_reg_arbiter_pkg::*;
#(
    parameter int  NUM_REQ        = 2,
    parameter int  AW             = 32,
    parameter int  DW             = 32,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    periph_reg_arbiter_if.slave  bus_if,
    output logic                 busy_o,
    output logic [GW-1:0]        grant_idx_o,
    output logic                 timeout_o
);

    localparam int WS = DW / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_e          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rrPtr;
    logic [CW-1:0]   r_count;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [WS-1:0]   r_wstrb;
    logic            r_slvValid;
    logic            r_busy;
    logic            r_timeout;

    logic            w_found;
    logic [GW-1:0]   w_pickIdx;
    logic [GW-1:0]   w_nextPtr;
    logic            w_timeoutHit;

    periph_reg_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rrPick (
        .i_valid (bus_if.req_valid_i),
        .i_rrPtr (r_rrPtr),
        .o_found (w_found),
        .o_idx   (w_pickIdx)
    );

    // After serving a requester the one above it gets first claim, which is
    // what keeps every pending requester from being starved.
    assign w_nextPtr = (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + GW'(1);

    // The counter sits at CNT_LAST in the last BUSY cycle the slave is allowed.
    assign w_timeoutHit = (TIMEOUT_CYCLES != 0) && (r_count == CNT_LAST);

    // Arbiter FSM. Grants from IDLE, latches the chosen request, holds it on
    // the slave while BUSY and either completes on slv_ready_i or gives up
    // through ABORT. Slave-side outputs and status flags are registered here
    // so they only change on clock edges (or reset).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rrPtr    <= '0;
            r_count    <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_slvValid <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_grant    <= w_pickIdx;
                        r_write    <= bus_if.req_write_i[w_pickIdx];
                        r_addr     <= bus_if.req_addr_i[int'(w_pickIdx)*AW +: AW];
                        r_wdata    <= bus_if.req_wdata_i[int'(w_pickIdx)*DW +: DW];
                        r_wstrb    <= bus_if.req_wstrb_i[int'(w_pickIdx)*WS +: WS];
                        r_count    <= '0;
                        r_slvValid <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus_if.slv_ready_i) begin
                        r_state    <= IDLE;
                        r_slvValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_rrPtr    <= w_nextPtr;
                    end else if (w_timeoutHit) begin
                        r_state    <= ABORT;
                        r_slvValid <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else if (r_count != CNT_MAX) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                ABORT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rrPtr <= w_nextPtr;
                end
                default: begin
                    r_state    <= IDLE;
                    r_slvValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // The response has to leave in the same cycle the slave answers, so it is
    // steered combinationally from slv_*; in ABORT the arbiter answers on the
    // slave's behalf. Everywhere else the response bus is held at zero.
    always_comb begin
        bus_if.rsp_ready_o = '0;
        bus_if.rsp_rdata_o = '0;
        bus_if.rsp_error_o = 1'b0;
        if (r_state == BUSY && bus_if.slv_ready_i) begin
            bus_if.rsp_ready_o[r_grant] = 1'b1;
            bus_if.rsp_rdata_o          = bus_if.slv_rdata_i;
            bus_if.rsp_error_o          = bus_if.slv_error_i;
        end else if (r_state == ABORT) begin
            bus_if.rsp_ready_o[r_grant] = 1'b1;
            bus_if.rsp_rdata_o          = DW'(ERR_RDATA);
            bus_if.rsp_error_o          = 1'b1;
        end
    end

    assign bus_if.slv_valid_o = r_slvValid;
    assign bus_if.slv_write_o = r_write;
    assign bus_if.slv_addr_o  = r_addr;
    assign bus_if.slv_wdata_o = r_wdata;
    assign bus_if.slv_wstrb_o = r_wstrb;

    assign busy_o      = r_busy;
    assign grant_idx_o = r_grant;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_periph_reg_arbiter
//   Drives three requesters and a scripted peripheral slave, and compares
//   the arbiter against a transaction-level reference (round-robin pointer,
//   latched fields, timeout after TO_CYCLES busy cycles).
// ---------------------------------------------------------------------------
module tb_periph_reg_arbiter;

    localparam int N         = 3;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int TO_CYCLES = 4;
    localparam int GW        = 2;

    logic          clk_i;
    logic          rst_i;
    logic          busy_o;
    logic [GW-1:0] grant_idx_o;
    logic          timeout_o;

    periph_reg_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) busIf ();

    periph_reg_arbiter #(
        .NUM_REQ        (N),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_if      (busIf),
        .busy_o      (busy_o),
        .grant_idx_o (grant_idx_o),
        .timeout_o   (timeout_o)
    );

    int          totalCnt;
    int          badCnt;
    int          mPtr;
    logic        reqWrite [N];
    logic [31:0] reqAddr  [N];
    logic [31:0] reqWdata [N];
    logic [3:0]  reqWstrb [N];

    // Free-running clock, active edge is posedge.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rule: the first valid requester scanning up from the pointer.
    function automatic int modelPick(input logic [N-1:0] v, input int ptr);
        int j;
        modelPick = -1;
        for (int k = N - 1; k >= 0; k--) begin
            j = (ptr + k) % N;
            if (v[j]) modelPick = j;
        end
    endfunction

    task automatic randomizeReqs();
        for (int i = 0; i < N; i++) begin
            reqWrite[i] = 1'($urandom_range(0, 1));
            reqAddr[i]  = $urandom;
            reqWdata[i] = $urandom;
            reqWstrb[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic driveReqs(input logic [N-1:0] v);
        busIf.req_valid_i = v;
        for (int i = 0; i < N; i++) begin
            busIf.req_write_i[i]          = reqWrite[i];
            busIf.req_addr_i[i*AW +: AW]  = reqAddr[i];
            busIf.req_wdata_i[i*DW +: DW] = reqWdata[i];
            busIf.req_wstrb_i[i*4 +: 4]   = reqWstrb[i];
        end
    endtask

    // Idle cycles with no requests: the arbiter must stay quiet.
    task automatic idleCycles(input int k);
        driveReqs('0);
        for (int c = 0; c < k; c++) begin
            @(negedge clk_i);
            checkOutput("idle_hold_busy", busy_o, 0);
            checkOutput("idle_hold_slv_valid", busIf.slv_valid_o, 0);
            checkOutput("idle_hold_rsp_ready", busIf.rsp_ready_o, 0);
            checkOutput("idle_hold_rsp_rdata", busIf.rsp_rdata_o, 0);
            @(posedge clk_i);
            #1;
        end
    endtask

    // One full transaction, entered at posedge+1 of an idle cycle. The slave
    // answers 'latency' busy cycles after slv_valid rises; a latency of
    // TO_CYCLES or more means it never answers and the arbiter must abort.
    task automatic applyStimulus(input logic [N-1:0] valid, input int latency,
                                 input logic slvErr, input logic [31:0] slvData,
                                 input bit lateReady, input bit jitter);
        int          g;
        bit          finished;
        logic        expWrite;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expWstrb;

        driveReqs(valid);
        g        = modelPick(valid, mPtr);
        expWrite = reqWrite[g];
        expAddr  = reqAddr[g];
        expWdata = reqWdata[g];
        expWstrb = reqWstrb[g];

        @(negedge clk_i);
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_slv_valid", busIf.slv_valid_o, 0);
        checkOutput("idle_rsp_ready", busIf.rsp_ready_o, 0);
        checkOutput("idle_timeout", timeout_o, 0);
        @(posedge clk_i);
        #1;

        finished = 1'b0;
        for (int n = 0; n < TO_CYCLES && !finished; n++) begin
            if (jitter) begin
                randomizeReqs();
                driveReqs(N'($urandom_range(0, (1 << N) - 1)));
            end
            busIf.slv_ready_i = (n == latency);
            busIf.slv_rdata_i = (n == latency) ? slvData : $urandom;
            busIf.slv_error_i = (n == latency) ? slvErr : 1'($urandom_range(0, 1));
            @(negedge clk_i);
            checkOutput("busy_slv_valid", busIf.slv_valid_o, 1);
            checkOutput("busy_flag", busy_o, 1);
            checkOutput("grant_idx", grant_idx_o, 64'(g));
            checkOutput("slv_write", busIf.slv_write_o, expWrite);
            checkOutput("slv_addr", busIf.slv_addr_o, expAddr);
            checkOutput("slv_wdata", busIf.slv_wdata_o, expWdata);
            checkOutput("slv_wstrb", busIf.slv_wstrb_o, expWstrb);
            checkOutput("busy_timeout", timeout_o, 0);
            if (n == latency) begin
                checkOutput("rsp_ready", busIf.rsp_ready_o, 64'(1) << g);
                checkOutput("rsp_rdata", busIf.rsp_rdata_o, slvData);
                checkOutput("rsp_error", busIf.rsp_error_o, slvErr);
                finished = 1'b1;
            end else begin
                checkOutput("wait_rsp_ready", busIf.rsp_ready_o, 0);
                checkOutput("wait_rsp_rdata", busIf.rsp_rdata_o, 0);
                checkOutput("wait_rsp_error", busIf.rsp_error_o, 0);
            end
            @(posedge clk_i);
            #1;
        end
        busIf.slv_ready_i = 1'b0;

        if (!finished) begin
            busIf.slv_ready_i = lateReady;
            busIf.slv_rdata_i = $urandom;
            busIf.slv_error_i = 1'b0;
            @(negedge clk_i);
            checkOutput("abort_slv_valid", busIf.slv_valid_o, 0);
            checkOutput("abort_busy", busy_o, 1);
            checkOutput("abort_rsp_ready", busIf.rsp_ready_o, 64'(1) << g);
            checkOutput("abort_rsp_error", busIf.rsp_error_o, 1);
            checkOutput("abort_rsp_rdata", busIf.rsp_rdata_o, 32'hBADCAB1E);
            checkOutput("abort_timeout", timeout_o, 1);
            checkOutput("abort_grant", grant_idx_o, 64'(g));
            @(posedge clk_i);
            #1;
        end
        mPtr = (g + 1) % N;
    endtask

    task automatic resetPulse();
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        mPtr  = 0;
    endtask

    initial begin
        logic [N-1:0] v;
        int           lat;

        totalCnt = 0;
        badCnt   = 0;
        mPtr     = 0;
        rst_i    = 1'b1;
        busIf.slv_ready_i = 1'b0;
        busIf.slv_rdata_i = '0;
        busIf.slv_error_i = 1'b0;
        randomizeReqs();
        driveReqs('0);

        // Reset state
        repeat (2) @(negedge clk_i);
        checkOutput("rst_slv_valid", busIf.slv_valid_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_grant", grant_idx_o, 0);
        checkOutput("rst_rsp_ready", busIf.rsp_ready_o, 0);
        checkOutput("rst_rsp_rdata", busIf.rsp_rdata_o, 0);
        checkOutput("rst_timeout", timeout_o, 0);
        checkOutput("rst_slv_addr", busIf.slv_addr_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Requester 0 reads 0x100, slave answers three cycles late
        reqWrite[0] = 1'b0;
        reqAddr[0]  = 32'h0000_0100;
        applyStimulus(3'b001, 3, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Two requesters held together from reset: grant order 0, 1, 0
        resetPulse();
        randomizeReqs();
        for (int i = 0; i < N; i++) reqWrite[i] = 1'b1;
        applyStimulus(3'b011, 0, 1'b0, $urandom, 1'b0, 1'b0);
        applyStimulus(3'b011, 1, 1'b0, $urandom, 1'b0, 1'b0);
        applyStimulus(3'b011, 2, 1'b0, $urandom, 1'b0, 1'b0);

        // Requester fields change while busy; slave side must not follow
        randomizeReqs();
        applyStimulus(3'b010, 3, 1'b0, $urandom, 1'b0, 1'b1);

        // Slave never answers: abort, then a late ready must be ignored
        randomizeReqs();
        applyStimulus(3'b001, 99, 1'b0, $urandom, 1'b1, 1'b0);
        idleCycles(2);
        busIf.slv_ready_i = 1'b0;

        // Slave reports an error on a write to 0x200
        randomizeReqs();
        reqWrite[2] = 1'b1;
        reqAddr[2]  = 32'h0000_0200;
        applyStimulus(3'b100, 1, 1'b1, 32'h0, 1'b0, 1'b0);

        // Reset while busy clears everything at once
        busIf.slv_ready_i = 1'b0;
        randomizeReqs();
        for (int i = 0; i < N; i++) begin
            reqAddr[i]  = 32'h1234_5670 + i;
            reqWdata[i] = 32'hCAFE_0000 + i;
            reqWstrb[i] = 4'hF;
            reqWrite[i] = 1'b1;
        end
        driveReqs(3'b011);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("prerst_slv_valid", busIf.slv_valid_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_slv_valid", busIf.slv_valid_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        checkOutput("midrst_grant", grant_idx_o, 0);
        checkOutput("midrst_slv_addr", busIf.slv_addr_o, 0);
        checkOutput("midrst_slv_wdata", busIf.slv_wdata_o, 0);
        checkOutput("midrst_slv_wstrb", busIf.slv_wstrb_o, 0);
        checkOutput("midrst_slv_write", busIf.slv_write_o, 0);
        checkOutput("midrst_rsp_ready", busIf.rsp_ready_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mPtr  = 0;
        applyStimulus(3'b010, 1, 1'b0, 32'h5A5A_0001, 1'b0, 1'b0);

        // Randomized traffic, including timeouts and idle gaps
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idleCycles($urandom_range(1, 2));
            end
            randomizeReqs();
            v   = N'($urandom_range(1, (1 << N) - 1));
            lat = $urandom_range(0, TO_CYCLES + 1);
            applyStimulus(v, lat, 1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    // Safety net in case the flow above ever stops advancing.
    initial begin
        #2000000;
        badCnt++;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
